mb_quad_buf: RTL

Parametrised memory-buffer block: a bank of `NWORDS` word slots (the MB0–MBn registers) with a registered output selector and odd parity. It adds a fill sequencer that accepts memory words in wrapped order and a drain sequencer that writes slots back with a ready/valid handshake. A `CHDEPTH`-entry channel buffer feeds a channel-load register. It sits between the cache/EBOX data paths and the memory/channel buses in the MBOX.

---
 rtl/mb_pkg.sv | 15 +
 rtl/mb_ch_ram.sv | 32 +++
 rtl/mb_quad_buf.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mb_pkg.sv
// mb_pkg: shared sequencer state type and direct-load source codes for the MB buffer
package mb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } mbState_t;

  localparam logic [1:0] MB_SRC_CACHE = 2'd0;
  localparam logic [1:0] MB_SRC_AR    = 2'd1;
  localparam logic [1:0] MB_SRC_MEM   = 2'd2;
  localparam logic [1:0] MB_SRC_CH    = 2'd3;

endpackage

// File: rtl/mb_ch_ram.sv
// mb_ch_ram: single-port synchronous RAM, read-first, no reset on the array
module mb_ch_ram #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 128,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_adr,
  input  logic [WIDTH-1:0] i_wd,
  output logic [WIDTH-1:0] o_rd
);

  logic [WIDTH-1:0] r_mem [DEPTH];

`ifdef MB_FPGA_BRAM
  // write port kept separate from the read register so block-RAM inference sees the standard template
  always_ff @(posedge clk)
    if (i_we) r_mem[i_adr] <= i_wd;

  // registered read returns the pre-write contents of the addressed entry
  always_ff @(posedge clk)
    o_rd <= r_mem[i_adr];
`else
  // behavioural model: same-address read during a write returns the old word
  always_ff @(posedge clk) begin
    o_rd <= r_mem[i_adr];
    if (i_we) r_mem[i_adr] <= i_wd;
  end
`endif

endmodule

// File: rtl/mb_quad_buf.sv
// mb_quad_buf: MB slot bank with output select, fill/drain sequencers and channel-load path
module mb_quad_buf
  import mb_pkg::*;
#(
  parameter int WIDTH   = 36,
  parameter int NWORDS  = 4,
  parameter int CHDEPTH = 128,
  localparam int WW = $clog2(NWORDS),
  localparam int CW = $clog2(CHDEPTH)
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [1:0]        srcSel,
  input  logic [WIDTH-1:0]  cacheData,
  input  logic [WIDTH-1:0]  arData,
  input  logic [WIDTH-1:0]  memData,
  input  logic [NWORDS-1:0] ldEn,
  input  logic [WW-1:0]     selIn,
  input  logic              selHold,
  output logic [WIDTH-1:0]  mb,
  output logic              mbParOdd,
  output logic [NWORDS-1:0] slotValid,
  input  logic              fillStart,
  input  logic [WW-1:0]     fillFirst,
  input  logic              memValid,
  input  logic              nxm,
  output logic              fillDone,
  output logic              fillErr,
  input  logic              drainStart,
  input  logic [WW-1:0]     drainFirst,
  output logic              drainValid,
  input  logic              drainReady,
  output logic [WIDTH-1:0]  drainData,
  output logic [WW-1:0]     drainWord,
  output logic              busy,
  input  logic              chWr,
  input  logic [CW-1:0]     chAdr,
  input  logic              chSrcMb,
  input  logic [WIDTH-1:0]  chReg,
  input  logic              chLoad,
  output logic [WIDTH-1:0]  chBufQ
);

  localparam logic [WW:0] LAST = (WW+1)'(NWORDS-1);

  mbState_t          r_state;
  logic [WW-1:0]     r_ptr;
  logic [WW:0]       r_cnt;
  logic [WIDTH-1:0]  r_slot [NWORDS];
  logic [NWORDS-1:0] r_valid;
  logic [WW-1:0]     r_sel;
  logic              r_done;
  logic              r_err;
  logic [WIDTH-1:0]  r_chq;
  logic [WIDTH-1:0]  w_src;
  logic [WIDTH-1:0]  w_ram_rd;
  logic              w_fill_wr;
  logic              w_fill_clr;

  // direct-load source mux and sequencer write qualifiers
  always_comb begin
    w_src = srcSel == MB_SRC_CACHE ? cacheData :
            srcSel == MB_SRC_AR    ? arData    :
            srcSel == MB_SRC_MEM   ? memData   : r_chq;
    w_fill_wr  = r_state == ST_FILL && memValid && !nxm;
    w_fill_clr = r_state == ST_IDLE && fillStart;
  end

  // fill/drain sequencer: pointer walks from the first word with wrap, count ends the burst
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE:
          if (fillStart) begin
            r_state <= ST_FILL;
            r_ptr   <= fillFirst;
            r_cnt   <= '0;
          end else if (drainStart) begin
            r_state <= ST_DRAIN;
            r_ptr   <= drainFirst;
            r_cnt   <= '0;
          end
        ST_FILL:
          if (nxm) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else if (memValid) begin
            r_ptr <= r_ptr + 1'b1;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        ST_DRAIN:
          if (drainReady) begin
            r_ptr <= r_ptr + 1'b1;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) r_state <= ST_IDLE;
          end
        default: r_state <= ST_IDLE;
      endcase
    end

  // slot bank: fill start clears valids, direct loads next, sequencer write last so it wins
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      r_valid <= '0;
      for (int i = 0; i < NWORDS; i++) r_slot[i] <= '0;
    end else begin
      if (w_fill_clr) r_valid <= '0;
      for (int i = 0; i < NWORDS; i++)
        if (ldEn[i]) begin
          r_slot[i]  <= w_src;
          r_valid[i] <= 1'b1;
        end
      if (w_fill_wr) begin
        r_slot[r_ptr]  <= memData;
        r_valid[r_ptr] <= 1'b1;
      end
    end

  // output select register and channel-load register
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      r_sel <= '0;
      r_chq <= '0;
    end else begin
      if (!selHold) r_sel <= selIn;
      if (chLoad) r_chq <= w_ram_rd;
    end

  mb_ch_ram #(.WIDTH(WIDTH), .DEPTH(CHDEPTH)) u_ch_ram (
    .clk   (clk),
    .i_we  (chWr),
    .i_adr (chAdr),
    .i_wd  (chSrcMb ? mb : chReg),
    .o_rd  (w_ram_rd)
  );

  assign mb         = r_slot[r_sel];
  assign mbParOdd   = ^mb;
  assign slotValid  = r_valid;
  assign fillDone   = r_done;
  assign fillErr    = r_err;
  assign drainValid = r_state == ST_DRAIN;
  assign drainData  = r_slot[r_ptr];
  assign drainWord  = r_ptr;
  assign busy       = r_state != ST_IDLE;
  assign chBufQ     = r_chq;

endmodule
